// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module : mem_arb_pkg
// Brief  : Shared types and constants for the fetch/data memory arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_align_check.sv
//------------------------------------------------------------------------------
// Module : mem_arb_align_check
// Brief  : Combinational funct3 legality and address alignment check.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arb_align_check (
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    input  logic       i_is_store,
    output logic       o_err
);

    logic w_bad_funct3;
    logic w_bad_store;
    logic w_half_mis;
    logic w_word_mis;

    assign w_bad_funct3 = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
    // Stores have no unsigned variants
    assign w_bad_store  = i_is_store & i_funct3[2];
    assign w_half_mis   = (i_funct3[1:0] == 2'b01) & i_addr_lo[0];
    assign w_word_mis   = (i_funct3[1:0] == 2'b10) & (|i_addr_lo);

    assign o_err = w_bad_funct3 | w_bad_store | w_half_mis | w_word_mis;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : mem_arbiter
// Brief  : Two-port (fetch/data) arbiter onto a single shared memory port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        mem_write_mem,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] c_LIMIT = 3'(STARVE_LIMIT);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_src_data;
    logic [2:0]  r_starve_cnt;

    logic w_arb_en;
    logic w_data_wins;
    logic w_i_gnt;
    logic w_d_gnt;
    logic w_i_mis;
    logic w_d_mis;
    logic w_i_read;
    logic w_d_read;
    logic w_d_store;
    logic w_in_resp;

    mem_arb_align_check u_fetch_chk (
        .i_funct3   (LW),
        .i_addr_lo  (i_addr[1:0]),
        .i_is_store (1'b0),
        .o_err      (w_i_mis)
    );

    mem_arb_align_check u_data_chk (
        .i_funct3   (d_funct3),
        .i_addr_lo  (d_addr[1:0]),
        .i_is_store (d_we),
        .o_err      (w_d_mis)
    );

    // Reset gates arbitration so no request is accepted while it is held
    assign w_in_resp   = (r_state == RESP);
    assign w_arb_en    = (r_state == IDLE) & ~reset;
    assign w_data_wins = d_req & (~i_req | (r_starve_cnt != c_LIMIT));
    assign w_d_gnt     = w_arb_en & w_data_wins;
    assign w_i_gnt     = w_arb_en & i_req & ~w_data_wins;

    assign w_i_read  = w_i_gnt & ~w_i_mis;
    assign w_d_read  = w_d_gnt & ~w_d_mis & ~d_we;
    assign w_d_store = w_d_gnt & ~w_d_mis & d_we;

    assign i_gnt = w_i_gnt;
    assign i_err = w_i_gnt & w_i_mis;
    assign d_gnt = w_d_gnt;
    assign d_err = w_d_gnt & w_d_mis;

    assign i_rvalid = w_in_resp & ~r_src_data;
    assign d_rvalid = w_in_resp & r_src_data;
    assign i_rdata  = i_rvalid ? mem_read_data : 32'd0;
    assign d_rdata  = d_rvalid ? mem_read_data : 32'd0;

    always_comb begin
        mem_write_mem     = 1'b0;
        mem_funct3        = LW;
        mem_write_address = 32'd0;
        mem_write_data    = 32'd0;
        mem_read_address  = 32'd0;
        if (w_in_resp) begin
            mem_read_address = r_addr;
            mem_funct3       = r_funct3;
        end else if (w_i_read) begin
            mem_read_address = i_addr;
            mem_funct3       = LW;
        end else if (w_d_read) begin
            mem_read_address = d_addr;
            mem_funct3       = d_funct3;
        end else if (w_d_store) begin
            mem_write_mem     = 1'b1;
            mem_write_address = d_addr;
            mem_write_data    = d_wdata;
            mem_funct3        = d_funct3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= 32'd0;
            r_funct3   <= 3'd0;
            r_src_data <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_read || w_d_read) begin
                        r_state    <= RESP;
                        r_addr     <= w_i_read ? i_addr : d_addr;
                        r_funct3   <= w_i_read ? LW : d_funct3;
                        r_src_data <= w_d_read;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Counts data grants that overtook a waiting fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 3'd0;
        end else if (!i_req || w_i_gnt) begin
            r_starve_cnt <= 3'd0;
        end else if (w_d_gnt && (r_starve_cnt != c_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end

endmodule

`default_nettype wire
